// File: rtl/mmix_mem_pkg.sv
// Shared types for the MMIX memory path: access-size codes, store-buffer entry and FSM states.
package mmix_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WYDE  = 2'd1;
  localparam logic [1:0] SZ_TETRA = 2'd2;
  localparam logic [1:0] SZ_OCTA  = 2'd3;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD, S_DONE} main_state_e;
  typedef enum logic {D_IDLE, D_BUSY} drain_state_e;

  // Keeps the low bytes of right-justified data that belong to an access of this size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_BYTE:  m = 64'h0000_0000_0000_00FF;
      SZ_WYDE:  m = 64'h0000_0000_0000_FFFF;
      SZ_TETRA: m = 64'h0000_0000_FFFF_FFFF;
      default:  m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_store_buffer_if.sv
// Core-side and bus_adapter-side handshake signals of the posted-store buffer.
interface mem_store_buffer_if;
  logic [63:0] cpu_address;
  logic [1:0]  cpu_datasize;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_sync;
  logic [63:0] cpu_writedata;
  logic [63:0] cpu_readdata;
  logic        cpu_done;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic        mem_done;

  // The store buffer: serves the core, drives bus_adapter.
  modport slave (
    input  cpu_address, cpu_datasize, cpu_read, cpu_write, cpu_sync, cpu_writedata,
    input  mem_readdata, mem_done,
    output cpu_readdata, cpu_done,
    output mem_address, mem_datasize, mem_read, mem_write, mem_writedata
  );

  // The surrounding core and bus_adapter.
  modport master (
    output cpu_address, cpu_datasize, cpu_read, cpu_write, cpu_sync, cpu_writedata,
    output mem_readdata, mem_done,
    input  cpu_readdata, cpu_done,
    input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/sb_fifo.sv
// DEPTH-entry store FIFO with an age-ordered view of all slots (index 0 = oldest).
module sb_fifo
  import mmix_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  sb_entry_t             i_push_entry,
  input  logic                  i_pop,
  output sb_entry_t             o_head,
  output sb_entry_t [DEPTH-1:0] o_entries,
  output logic [PTR_W:0]        o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne = (PTR_W + 1)'(1);

  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[r_rd_ptr + PTR_W'(i)];
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store buffer between the MMIX load/store unit and bus_adapter.
// Optional STORE_FWD_EN: exact-match loads are served from the newest buffered store.
module mem_store_buffer
  import mmix_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  mem_store_buffer_if.slave bus,
  output logic [PTR_W:0]    buf_count,
  output logic              buf_empty
);

  main_state_e  r_state, w_state_d;
  drain_state_e r_drain, w_drain_d;
  logic         r_is_read, w_is_read_d;

  logic                  w_push, w_pop, w_full, w_fifo_empty, w_buf_empty;
  logic                  w_load_start, w_load_done, w_fwd_take, w_drain_start;
  logic [PTR_W:0]        w_count;
  sb_entry_t             w_head, w_push_entry;
  sb_entry_t [DEPTH-1:0] w_entries;
  logic                  w_fwd_hit;
  logic [63:0]           w_fwd_data;

  logic [63:0] r_mem_address, r_mem_writedata, r_cpu_readdata;
  logic [1:0]  r_mem_datasize;
  logic        r_mem_read, r_mem_write;

  assign w_push_entry = '{addr: bus.cpu_address, size: bus.cpu_datasize, data: bus.cpu_writedata};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_fifo_empty)
  );

  assign w_buf_empty = w_fifo_empty && (r_drain == D_IDLE);
  assign w_load_done = (r_state == S_LOAD) && bus.mem_done;

`ifdef STORE_FWD_EN
  // Later (younger) matches override earlier ones.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W + 1)'(i) < w_count) && (w_entries[i].addr == bus.cpu_address) &&
          (w_entries[i].size == bus.cpu_datasize)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entries[i].data & size_mask(w_entries[i].size);
      end
    end
  end
`else
  logic w_unused_entries;
  assign w_unused_entries = ^w_entries;
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_is_read_d  = r_is_read;
    w_push       = 1'b0;
    w_load_start = 1'b0;
    w_fwd_take   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_write) begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_state_d = S_DONE;
          end
        end else if (bus.cpu_read) begin
          w_is_read_d = 1'b1;
          if (w_fwd_hit) begin
            w_fwd_take = 1'b1;
            w_state_d  = S_DONE;
          end else if (w_buf_empty) begin
            w_load_start = 1'b1;
            w_state_d    = S_LOAD;
          end else begin
            w_state_d = S_DRAIN;
          end
        end else if (bus.cpu_sync) begin
          w_is_read_d = 1'b0;
          w_state_d   = w_buf_empty ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_buf_empty) begin
          w_load_start = r_is_read;
          w_state_d    = r_is_read ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:  if (bus.mem_done) w_state_d = S_DONE;
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_drain_d     = r_drain;
    w_drain_start = 1'b0;
    w_pop         = 1'b0;
    unique case (r_drain)
      D_IDLE: begin
        if ((w_count != '0) && (r_state != S_LOAD)) begin
          w_drain_start = 1'b1;
          w_drain_d     = D_BUSY;
        end
      end
      D_BUSY: begin
        if (bus.mem_done) begin
          w_pop     = 1'b1;
          w_drain_d = D_IDLE;
        end
      end
      default: w_drain_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_drain   <= D_IDLE;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_drain   <= w_drain_d;
      r_is_read <= w_is_read_d;
    end
  end

  // Drain and load never start together: a load starts only with the FIFO empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_address   <= '0;
      r_mem_datasize  <= '0;
      r_mem_writedata <= '0;
      r_mem_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_cpu_readdata  <= '0;
    end else begin
      if (w_drain_start) begin
        r_mem_address   <= w_head.addr;
        r_mem_datasize  <= w_head.size;
        r_mem_writedata <= w_head.data;
        r_mem_write     <= 1'b1;
      end else if (w_pop) begin
        r_mem_write <= 1'b0;
      end
      if (w_load_start) begin
        r_mem_address  <= bus.cpu_address;
        r_mem_datasize <= bus.cpu_datasize;
        r_mem_read     <= 1'b1;
      end else if (w_load_done) begin
        r_mem_read <= 1'b0;
      end
      if (w_load_done) begin
        r_cpu_readdata <= bus.mem_readdata;
      end else if (w_fwd_take) begin
        r_cpu_readdata <= w_fwd_data;
      end
    end
  end

  assign bus.cpu_readdata  = r_cpu_readdata;
  assign bus.cpu_done      = (r_state == S_DONE);
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_datasize  = r_mem_datasize;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_writedata = r_mem_writedata;
  assign buf_count         = w_count;
  assign buf_empty         = w_buf_empty;

endmodule
